control_word_sequencer: RTL and testbench
=========================================

# control_word_sequencer

Parametrised, programmable control-word generator for the simple processor datapath. It accepts a state code from the main state machine through a valid/ready handshake, looks the code up in a writable table of control words and dwell counts, and drives the registered control word onto the datapath. Each word is held for a programmable number of cycles, with stall and back-to-back support. The block replaces a fixed, hard-coded state-to-control-word decode, so new instructions need only a table reprogram.

## Interface
- STATE_W, 6, width of state code and table address
- CTRL_W, 20, control word width
- NUM_STATES, 64, table entries; legal range 2..2**STATE_W
- DWELL_W, 3, dwell count width; a word is held for dwell+1 cycles

- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- state  in  STATE_W  state code from the state machine
- state_valid  in  1  state code is presented
- state_ready  out  1  block can accept a state this cycle (combinational)
- stall  in  1  freeze the current step; hold word and dwell counter
- cfg_we  in  1  table write strobe
- cfg_addr  in  STATE_W  table entry to write
- cfg_word  in  CTRL_W  control word to write
- cfg_dwell  in  DWELL_W  dwell count to write
- control_out  out  CTRL_W  registered control word to the datapath
- busy  out  1  a step is being driven
- step_done  out  1  one-cycle pulse on the final cycle of a step
- err  out  1  one-cycle pulse: illegal state accepted, or illegal cfg_addr written

## Operation
- Table: NUM_STATES entries of {word[CTRL_W], dwell[DWELL_W]}, flop-based. Reset clears every entry to word 0 and dwell 0.
- The FSM has two states, IDLE and RUN, plus a down-counter `cnt` [DWELL_W].
- state_ready = (IDLE) or (RUN and cnt==0 and !stall).
- Accept = state_valid and state_ready.
  - On accept: control_out <= table[state].word, cnt <= table[state].dwell, and the FSM goes to RUN.
- RUN, stall=1: control_out, cnt and the FSM all hold. step_done stays 0.
- RUN, stall=0, cnt>0: cnt decrements.
- RUN, stall=0, cnt==0: this is the final cycle, and step_done=1.
  - With an accept on the same cycle, the next step loads with no bubble.
  - Without an accept, the FSM goes to IDLE and control_out <= 0 on the next edge.
- busy = RUN.
- Illegal state (state >= NUM_STATES) accepted:
  - control_out <= 0 and cnt <= 0, so the step is one cycle of zero word.
  - err pulses on the cycle following the accept.
- Config writes are allowed in any FSM state.
  - A write with cfg_addr < NUM_STATES updates the entry on the edge.
  - A write with cfg_addr >= NUM_STATES is ignored, and err pulses next cycle.
- A write and an accept that hit the same entry on the same cycle: the accept uses the old contents (read before write).
- A write to the entry currently being driven does not change control_out or cnt of the running step.
- stall is ignored in IDLE.

## Timing
- Reset values: control_out=0, busy=0, step_done=0, err=0, FSM=IDLE, cnt=0, state_ready=1 (after reset deasserts).
- Latency: accept on edge t gives control_out valid from t+1.
- With no stalls, the word is held for cycles t+1 .. t+1+dwell. step_done is high in cycle t+1+dwell.
- Each stall cycle during RUN extends the step by one cycle.
- Back-to-back steps: a new accept in the step_done cycle gives the new word in the next cycle, with no zero gap.
- Reset mid-step: the step is abandoned at the reset edge. All outputs and the table go to reset values, and pending dwell is lost.
- reset has priority over cfg_we and accept on the same edge.

## Test plan
- **Reset state:** Reset, then read table entries via accept with no programming -> control_out=0 for 1 cycle per accept; busy and step_done behave as for dwell 0; err=0.
- **Single step:** Program entry 1 = {20'd135328, dwell 0} and entry 3 = {20'd133152, dwell 3}. Accept 1 at t -> control_out=135328 in t+1 only, step_done at t+1, control_out=0 at t+2. Accept 3 -> 133152 for 4 cycles, step_done on the 4th.
- **Stall and back-to-back:**
  - Entry 7 = {20'd36896, dwell 1}. Accept 7; assert stall for 2 cycles mid-step -> word held 4 cycles total; step_done on the last; state_ready=0 during stall.
  - With state_valid held continuously on entries 7 then 19 = {20'd1037, dwell 0} -> 36896, 36896, 1037, with no zero cycle between steps.
- **Illegal accesses:** NUM_STATES=22. Accept state 40 -> control_out=0 one cycle, err pulse. cfg_we to cfg_addr 30 -> no table change, err pulse.
- **Write collisions:**
  - Accept 5 while writing entry 5 = {20'd65616, dwell 2} on the same cycle -> old word (0) driven.
  - Next accept of 5 -> 65616 for 3 cycles.
  - Rewrite entry 5 mid-step -> running word unchanged.
- **Reset mid-step:** Entry 2 = {20'd147488, dwell 7}. Accept 2; pulse reset at cycle 3 -> next cycle control_out=0, busy=0; re-accept 2 -> 0, since the table was cleared.

Source files
------------

// File: rtl/control_word_sequencer.sv
// Table-driven control-word generator: state code in, registered control word held dwell+1 cycles.
// Latency: 1 cycle from accept to control_out. Backpressure: state_ready low while a step has cycles left or stall is high.
module control_word_sequencer #(
    parameter int STATE_W    = 6,
    parameter int CTRL_W     = 20,
    parameter int NUM_STATES = 64,
    parameter int DWELL_W    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic               state_valid,
    output logic               state_ready,
    input  logic               stall,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_addr,
    input  logic [CTRL_W-1:0]  cfg_word,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [CTRL_W-1:0]  control_out,
    output logic               busy,
    output logic               step_done,
    output logic               err
);

    localparam logic [STATE_W:0] NUM_L = (STATE_W+1)'(NUM_STATES);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               err_q;

    logic [CTRL_W-1:0]  word_tbl  [NUM_STATES];
    logic [DWELL_W-1:0] dwell_tbl [NUM_STATES];

    logic [CTRL_W-1:0]  rd_word;
    logic [DWELL_W-1:0] rd_dwell;
    logic               accept;
    logic               state_bad;
    logic               addr_bad;

    assign state_bad = ({1'b0, state} >= NUM_L);
    assign addr_bad  = ({1'b0, cfg_addr} >= NUM_L);

    // An out-of-range code matches no entry, so it reads as word 0 / dwell 0.
    always_comb begin
        rd_word  = '0;
        rd_dwell = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (state == STATE_W'(i)) begin
                rd_word  = word_tbl[i];
                rd_dwell = dwell_tbl[i];
            end
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        state_ready = 1'b0;
        step_done   = 1'b0;
        case (fsm_q)
            IDLE: state_ready = 1'b1;
            RUN: begin
                if (!stall) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
                        step_done   = 1'b1;
                        state_ready = 1'b1;
                        fsm_d       = IDLE;
                        ctrl_d      = '0;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
        accept = state_valid && state_ready;
        if (accept) begin
            ctrl_d = rd_word;
            cnt_d  = rd_dwell;
            fsm_d  = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            ctrl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            ctrl_q <= ctrl_d;
            err_q  <= (accept && state_bad) || (cfg_we && addr_bad);
        end
    end

    // Table writes land on the edge, so a same-cycle accept reads the old entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                word_tbl[i]  <= '0;
                dwell_tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STATES; i++) begin
                if (cfg_we && cfg_addr == STATE_W'(i)) begin
                    word_tbl[i]  <= cfg_word;
                    dwell_tbl[i] <= cfg_dwell;
                end
            end
        end
    end

    assign control_out = ctrl_q;
    assign busy        = (fsm_q == RUN);
    assign err         = err_q;

endmodule

// File: tb/tb_control_word_sequencer.sv
// Randomized and directed bench for control_word_sequencer against a step-level reference model.
module tb_control_word_sequencer;

    localparam int SW = 6;
    localparam int CW = 20;
    localparam int NS = 22;
    localparam int DW = 3;

    logic          clock = 1'b0;
    logic          rst;
    logic [SW-1:0] st;
    logic          sv;
    logic          stl;
    logic          we;
    logic [SW-1:0] ca;
    logic [CW-1:0] cw;
    logic [DW-1:0] cd;
    logic          state_ready;
    logic [CW-1:0] control_out;
    logic          busy;
    logic          step_done;
    logic          err;

    int checks = 0;
    int failures = 0;

    control_word_sequencer #(.STATE_W(SW), .CTRL_W(CW), .NUM_STATES(NS), .DWELL_W(DW)) dut (
        .clock       (clock),
        .reset       (rst),
        .state       (st),
        .state_valid (sv),
        .state_ready (state_ready),
        .stall       (stl),
        .cfg_we      (we),
        .cfg_addr    (ca),
        .cfg_word    (cw),
        .cfg_dwell   (cd),
        .control_out (control_out),
        .busy        (busy),
        .step_done   (step_done),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Reference model: a step is "word w for N remaining non-stalled cycles".
    logic [CW-1:0] m_word [NS];
    int            m_dwell[NS];
    bit            m_act;
    int            m_left;
    logic [CW-1:0] m_cur;
    bit            m_err;

    logic [CW-1:0] e_ctrl;
    logic          e_busy, e_rdy, e_done, e_err;

    task automatic model_outputs();
        e_busy = m_act;
        e_ctrl = m_act ? m_cur : '0;
        e_rdy  = !m_act || (m_left == 1 && !stl);
        e_done = m_act && m_left == 1 && !stl;
        e_err  = m_err;
    endtask

    task automatic model_edge();
        bit acc;
        int s;
        int a;
        s = int'(st);
        a = int'(ca);
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_word[i]  = '0;
                m_dwell[i] = 0;
            end
            m_act = 0; m_left = 0; m_cur = '0; m_err = 0;
        end else begin
            acc   = sv && (!m_act || (m_left == 1 && !stl));
            m_err = (acc && s >= NS) || (we && a >= NS);
            if (acc) begin
                m_act = 1;
                if (s < NS) begin
                    m_cur  = m_word[s];
                    m_left = m_dwell[s] + 1;
                end else begin
                    m_cur  = '0;
                    m_left = 1;
                end
            end else if (m_act && !stl) begin
                m_left--;
                if (m_left == 0) m_act = 0;
            end
            if (we && a < NS) begin
                m_word[a]  = cw;
                m_dwell[a] = int'(cd);
            end
        end
    endtask

    task automatic idle_in();
        rst = 1'b0; sv = 1'b0; st = '0; stl = 1'b0;
        we = 1'b0; ca = '0; cw = '0; cd = '0;
    endtask

    task automatic set_acc(input int s);
        sv = 1'b1; st = SW'(s);
    endtask

    task automatic set_wr(input int a, input logic [CW-1:0] w, input int d);
        we = 1'b1; ca = SW'(a); cw = w; cd = DW'(d);
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clock); model_edge(); #1;
        end
        idle_in();
        @(negedge clock); model_outputs();
        checks++;
        if ({control_out, busy, step_done, err, state_ready} !== {{CW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values ctrl=%0d busy=%b done=%b err=%b rdy=%b (required 0 0 0 0 1)",
                     control_out, busy, step_done, err, state_ready);
        end
        @(posedge clock); model_edge(); #1;
        for (int i = 0; i < 7; i++) begin
            idle_in();
            if (i < 4) set_acc(i);
            @(negedge clock); model_outputs();
            checks++;
            if ({control_out, busy, state_ready, step_done, err} !== {e_ctrl, e_busy, e_rdy, e_done, e_err}) begin
                failures++;
                $display("FAIL reset_read cyc=%0d got ctrl=%0d busy=%b rdy=%b done=%b err=%b required ctrl=%0d busy=%b rdy=%b done=%b err=%b",
                         i, control_out, busy, state_ready, step_done, err, e_ctrl, e_busy, e_rdy, e_done, e_err);
            end
            @(posedge clock); model_edge(); #1;
        end
    endtask

    task automatic test_single_step();
        for (int i = 0; i < 14; i++) begin
            idle_in();
            case (i)
                0: set_wr(1, 20'd135328, 0);
                1: set_wr(3, 20'd133152, 3);
                2: set_acc(1);
                6: set_acc(3);
                default: ;
            endcase
            @(negedge clock); model_outputs();
            checks++;
            if ({control_out, busy, state_ready, step_done, err} !== {e_ctrl, e_busy, e_rdy, e_done, e_err}) begin
                failures++;
                $display("FAIL single_step cyc=%0d got ctrl=%0d busy=%b rdy=%b done=%b err=%b required ctrl=%0d busy=%b rdy=%b done=%b err=%b",
                         i, control_out, busy, state_ready, step_done, err, e_ctrl, e_busy, e_rdy, e_done, e_err);
            end
            if (i == 3 || i == 10) begin
                checks++;
                if (control_out !== (i == 3 ? 20'd135328 : 20'd133152) || step_done !== 1'b1) begin
                    failures++;
                    $display("FAIL single_step_last cyc=%0d ctrl=%0d done=%b", i, control_out, step_done);
                end
            end
            @(posedge clock); model_edge(); #1;
        end
    endtask

    task automatic test_stall_back_to_back();
        for (int i = 0; i < 14; i++) begin
            idle_in();
            case (i)
                0: set_wr(7, 20'd36896, 1);
                1: set_wr(19, 20'd1037, 0);
                2: set_acc(7);
                3, 4: stl = 1'b1;
                8, 9: set_acc(7);
                10: set_acc(19);
                default: ;
            endcase
            @(negedge clock); model_outputs();
            checks++;
            if ({control_out, busy, state_ready, step_done, err} !== {e_ctrl, e_busy, e_rdy, e_done, e_err}) begin
                failures++;
                $display("FAIL stall_b2b cyc=%0d got ctrl=%0d busy=%b rdy=%b done=%b err=%b required ctrl=%0d busy=%b rdy=%b done=%b err=%b",
                         i, control_out, busy, state_ready, step_done, err, e_ctrl, e_busy, e_rdy, e_done, e_err);
            end
            if (i == 4) begin
                checks++;
                if (state_ready !== 1'b0 || control_out !== 20'd36896) begin
                    failures++;
                    $display("FAIL stall_hold rdy=%b ctrl=%0d (required 0 36896)", state_ready, control_out);
                end
            end
            if (i == 11) begin
                checks++;
                if (control_out !== 20'd1037) begin
                    failures++;
                    $display("FAIL b2b_no_gap ctrl=%0d (required 1037)", control_out);
                end
            end
            @(posedge clock); model_edge(); #1;
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 8; i++) begin
            idle_in();
            case (i)
                0: set_acc(40);
                3: set_wr(30, 20'hABCDE, 5);
                5: set_acc(8);
                default: ;
            endcase
            @(negedge clock); model_outputs();
            checks++;
            if ({control_out, busy, state_ready, step_done, err} !== {e_ctrl, e_busy, e_rdy, e_done, e_err}) begin
                failures++;
                $display("FAIL illegal cyc=%0d got ctrl=%0d busy=%b rdy=%b done=%b err=%b required ctrl=%0d busy=%b rdy=%b done=%b err=%b",
                         i, control_out, busy, state_ready, step_done, err, e_ctrl, e_busy, e_rdy, e_done, e_err);
            end
            if (i == 1 || i == 4) begin
                checks++;
                if (err !== 1'b1 || control_out !== '0) begin
                    failures++;
                    $display("FAIL illegal_err cyc=%0d err=%b ctrl=%0d (required 1 0)", i, err, control_out);
                end
            end
            @(posedge clock); model_edge(); #1;
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 12; i++) begin
            idle_in();
            case (i)
                0: begin set_acc(5); set_wr(5, 20'd65616, 2); end
                3: set_acc(5);
                5: set_wr(5, 20'd777, 1);
                8: set_acc(5);
                default: ;
            endcase
            @(negedge clock); model_outputs();
            checks++;
            if ({control_out, busy, state_ready, step_done, err} !== {e_ctrl, e_busy, e_rdy, e_done, e_err}) begin
                failures++;
                $display("FAIL collision cyc=%0d got ctrl=%0d busy=%b rdy=%b done=%b err=%b required ctrl=%0d busy=%b rdy=%b done=%b err=%b",
                         i, control_out, busy, state_ready, step_done, err, e_ctrl, e_busy, e_rdy, e_done, e_err);
            end
            if (i == 1 || i == 6) begin
                checks++;
                if (control_out !== (i == 1 ? 20'd0 : 20'd65616)) begin
                    failures++;
                    $display("FAIL collision_word cyc=%0d ctrl=%0d", i, control_out);
                end
            end
            @(posedge clock); model_edge(); #1;
        end
    endtask

    task automatic test_reset_mid_step();
        for (int i = 0; i < 10; i++) begin
            idle_in();
            case (i)
                0: set_wr(2, 20'd147488, 7);
                1: set_acc(2);
                4: rst = 1'b1;
                6: set_acc(2);
                default: ;
            endcase
            @(negedge clock); model_outputs();
            checks++;
            if ({control_out, busy, state_ready, step_done, err} !== {e_ctrl, e_busy, e_rdy, e_done, e_err}) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got ctrl=%0d busy=%b rdy=%b done=%b err=%b required ctrl=%0d busy=%b rdy=%b done=%b err=%b",
                         i, control_out, busy, state_ready, step_done, err, e_ctrl, e_busy, e_rdy, e_done, e_err);
            end
            if (i == 5 || i == 7) begin
                checks++;
                if (control_out !== '0 || busy !== (i == 7)) begin
                    failures++;
                    $display("FAIL reset_mid_clear cyc=%0d ctrl=%0d busy=%b", i, control_out, busy);
                end
            end
            @(posedge clock); model_edge(); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            idle_in();
            rst = ($urandom_range(0, 79) == 0);
            sv  = ($urandom_range(0, 2) != 0);
            st  = SW'($urandom_range(0, 25));
            stl = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0)
                set_wr($urandom_range(0, 25), CW'($urandom), $urandom_range(0, 7));
            @(negedge clock); model_outputs();
            checks++;
            if ({control_out, busy, state_ready, step_done, err} !== {e_ctrl, e_busy, e_rdy, e_done, e_err}) begin
                failures++;
                $display("FAIL random cyc=%0d got ctrl=%0d busy=%b rdy=%b done=%b err=%b required ctrl=%0d busy=%b rdy=%b done=%b err=%b",
                         i, control_out, busy, state_ready, step_done, err, e_ctrl, e_busy, e_rdy, e_done, e_err);
            end
            @(posedge clock); model_edge(); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_stall_back_to_back();
        test_illegal();
        test_collision();
        test_reset_mid_step();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
